// File: rtl/alarm_sequencer.sv
// alarm_sequencer: supervisory FSM for arming, entry/exit delays, alarm and failed-code lockout.
module alarm_sequencer #(
  parameter int CNT_W          = 16,
  parameter int EXIT_CYCLES    = 1000,
  parameter int ENTRY_CYCLES   = 500,
  parameter int LOCKOUT_CYCLES = 2000,
  parameter int MAX_FAILS      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       code_valid,
  input  logic       code_match,
  input  logic       is_breach,
  output logic       is_enabled,
  output logic       led_green,
  output logic       led_red,
  output logic       siren,
  output logic       alert_authorities,
  output logic       lockout,
  output logic       buf_clear,
  output logic [2:0] fail_count,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    DISARMED    = 3'd0,
    EXIT_DELAY  = 3'd1,
    ARMED       = 3'd2,
    ENTRY_DELAY = 3'd3,
    ALARM       = 3'd4,
    LOCKOUT     = 3'd5
  } state_t;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic [2:0]         fail_q, fail_d, fail_inc;
  logic               match, fail, thr, expired;
  logic               en_q, green_q, red_q, siren_q, alert_q, lock_q, bufclr_q;
  assign match    = code_valid & code_match;
  assign fail     = code_valid & ~code_match;
  assign fail_inc = (fail_q == 3'd7) ? 3'd7 : fail_q + 3'd1;
  assign thr      = ({1'b0, fail_q} + 4'd1) >= 4'(MAX_FAILS);
  assign expired  = timer_q == '0;
  always_comb begin
    state_d = state_q;
    fail_d  = fail_q;
    case (state_q)
      DISARMED: begin
        if (match) begin
          state_d = EXIT_DELAY;
          fail_d  = '0;
        end else if (fail) begin
          fail_d  = fail_inc;
          state_d = thr ? LOCKOUT : DISARMED;
        end
      end
      EXIT_DELAY: begin
        if (match) begin
          state_d = DISARMED;
          fail_d  = '0;
        end else begin
          fail_d  = fail ? fail_inc : fail_q;
          state_d = (fail && thr) ? ALARM : expired ? ARMED : EXIT_DELAY;
        end
      end
      ARMED: begin
        if (match) begin
          state_d = DISARMED;
          fail_d  = '0;
        end else begin
          fail_d  = fail ? fail_inc : fail_q;
          state_d = (fail && thr) ? ALARM : is_breach ? ENTRY_DELAY : ARMED;
        end
      end
      ENTRY_DELAY: begin
        if (match) begin
          state_d = DISARMED;
          fail_d  = '0;
        end else begin
          fail_d  = fail ? fail_inc : fail_q;
          state_d = ((fail && thr) || expired) ? ALARM : ENTRY_DELAY;
        end
      end
      ALARM: begin
        state_d = match ? DISARMED : ALARM;
        fail_d  = match ? 3'd0 : fail ? fail_inc : fail_q;
      end
      LOCKOUT: begin
        state_d = expired ? DISARMED : LOCKOUT;
        fail_d  = expired ? 3'd0 : fail_q;
      end
      default: state_d = DISARMED;
    endcase
    // Any state change reloads the timer; staying in a state counts it down.
    timer_d = (state_d == state_q) ? timer_q - CNT_W'(1) :
              (state_d == EXIT_DELAY)  ? CNT_W'(EXIT_CYCLES - 1) :
              (state_d == ENTRY_DELAY) ? CNT_W'(ENTRY_CYCLES - 1) :
              (state_d == LOCKOUT)     ? CNT_W'(LOCKOUT_CYCLES - 1) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DISARMED;
      timer_q  <= '0;
      fail_q   <= '0;
      en_q     <= 1'b0;
      green_q  <= 1'b1;
      red_q    <= 1'b0;
      siren_q  <= 1'b0;
      alert_q  <= 1'b0;
      lock_q   <= 1'b0;
      bufclr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      fail_q   <= fail_d;
      en_q     <= state_d inside {EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM};
      green_q  <= state_d == DISARMED;
      red_q    <= state_d != DISARMED;
      siren_q  <= state_d == ALARM;
      alert_q  <= (state_d == ALARM) && (state_q != ALARM);
      lock_q   <= state_d == LOCKOUT;
      bufclr_q <= code_valid;
    end
  end
  assign is_enabled        = en_q;
  assign led_green         = green_q;
  assign led_red           = red_q;
  assign siren             = siren_q;
  assign alert_authorities = alert_q;
  assign lockout           = lock_q;
  assign buf_clear         = bufclr_q;
  assign fail_count        = fail_q;
  assign state             = state_q;
endmodule

// File: doc/alarm_sequencer.md
Name: alarm_sequencer

Overview:
- Supervisory controller for the keypad security system.
- Consumes per-attempt results from the keypad passcode checker (one pulse per completed 4-digit entry, with a match flag) plus the breach sensor.
- Sequences arming: exit delay, armed, entry delay, alarm, and failed-attempt lockout.
- Drives the system-enable, status LEDs, siren and authority-alert outputs, and tells the keypad when to clear its input buffer.

Parameters:
- CNT_W, 16: width of the delay/lockout timer.
- EXIT_CYCLES, 1000: cycles spent in EXIT_DELAY before ARMED (>=1).
- ENTRY_CYCLES, 500: cycles spent in ENTRY_DELAY before ALARM (>=1).
- LOCKOUT_CYCLES, 2000: cycles spent in LOCKOUT (>=1).
- MAX_FAILS, 3: consecutive wrong codes that trigger lockout or alarm (1..7).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- code_valid  in  1  one-cycle pulse: a complete passcode attempt is available
- code_match  in  1  qualifies code_valid: 1 = correct passcode
- is_breach  in  1  level, security sensor tripped
- is_enabled  out  1  system armed (EXIT_DELAY, ARMED, ENTRY_DELAY, ALARM)
- led_green  out  1  1 in DISARMED only
- led_red  out  1  1 in every state except DISARMED
- siren  out  1  1 in ALARM
- alert_authorities  out  1  one-cycle pulse on entry to ALARM
- lockout  out  1  1 in LOCKOUT
- buf_clear  out  1  one-cycle pulse the cycle after every accepted or ignored code_valid
- fail_count  out  3  current consecutive-failure count
- state  out  3  encoded state, for debug

Behaviour:
- Reset and register timing
  - One clock, clk. rst is synchronous and active-high.
  - On rst: state=DISARMED(0), timer=0, fail_count=0, led_green=1, all other outputs 0.
  - rst overrides all inputs, including mid-delay and mid-alarm.
- State encoding: DISARMED=0, EXIT_DELAY=1, ARMED=2, ENTRY_DELAY=3, ALARM=4, LOCKOUT=5. Codes 6 and 7 recover to DISARMED on the next edge.
- Output timing
  - All outputs are registered and change on the same edge as state (Moore, zero extra latency).
  - alert_authorities is high only in the first cycle of ALARM.
- Terms: "match" = code_valid & code_match; "fail" = code_valid & ~code_match.
- Timer
  - Loaded with N-1 on entry to a timed state, where N is EXIT_CYCLES, ENTRY_CYCLES or LOCKOUT_CYCLES.
  - Decrements each cycle in that state; the exit transition fires on the edge where timer==0.
  - Result: exactly N cycles in the state.
- fail_count
  - Cleared on any match and on leaving LOCKOUT.
  - Incremented on fail, saturating at 7.
  - The threshold test uses the incremented value (fail_count+1 >= MAX_FAILS).
- Transitions (priority top-down within each state):
  - DISARMED: match -> EXIT_DELAY; fail reaching threshold -> LOCKOUT; other fail -> stay, count++. Breach ignored.
  - EXIT_DELAY: match -> DISARMED (cancel); fail reaching threshold -> ALARM; timer==0 -> ARMED. Breach ignored.
  - ARMED: match -> DISARMED; fail reaching threshold -> ALARM; is_breach -> ENTRY_DELAY.
  - ENTRY_DELAY: match -> DISARMED; fail reaching threshold -> ALARM; timer==0 -> ALARM. Breach level ignored.
  - ALARM: match -> DISARMED; fail -> stay, count++ (saturating). Remains until a correct code or rst.
  - LOCKOUT: code_valid ignored (no count change, buf_clear still pulses); timer==0 -> DISARMED with fail_count=0.
- Simultaneous events
  - Match beats breach and beats timer expiry in the same cycle.
  - Fail-threshold beats timer expiry.
  - Breach in the same cycle as an ARMED non-threshold fail: count++ and go to ENTRY_DELAY.
- code_match is don't-care when code_valid=0. Back-to-back code_valid pulses are each processed.

Test Plan (EXIT_CYCLES=4, ENTRY_CYCLES=3, LOCKOUT_CYCLES=5, MAX_FAILS=3):
1. Reset, then match pulse -> state 1 and led_red=1 next edge; state 2 exactly 4 cycles later; is_enabled=1 throughout; buf_clear pulses once.
2. Armed, raise is_breach for 1 cycle, no code -> ENTRY_DELAY for 3 cycles, then ALARM; siren=1; alert_authorities high exactly 1 cycle; match -> DISARMED, led_green=1, siren=0.
3. Armed, breach, match on the 3rd ENTRY_DELAY cycle (same edge as expiry) -> DISARMED; alert_authorities never asserted.
4. DISARMED, 3 fail pulses -> fail_count 1, 2, then LOCKOUT with lockout=1; a match during LOCKOUT is ignored; DISARMED with fail_count=0 after 5 cycles.
5. Armed, 2 fails then 1 match -> fail_count returns to 0, state DISARMED; repeat with 3 fails -> ALARM.
6. rst asserted during EXIT_DELAY (timer=2) -> next edge: state 0, all outputs at reset values; a later match restarts the full 4-cycle exit delay.
